// File: rtl/lab3_serial_sub.sv
//==============================================================================
// Module  : lab3_serial_sub
// Brief   : Nibble-serial wide subtractor, D = X - Y - Bin, with a registered
//           borrow between nibbles and a start/busy/done handshake.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module lab3_serial_sub #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4*NIB-1:0] X,
    input  logic [4*NIB-1:0] Y,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [4*NIB-1:0] D,
    output logic             Bout
);

    localparam int c_w  = 4 * NIB;
    localparam int c_iw = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [c_iw-1:0] c_last = c_iw'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [c_w-1:0]    r_x;
    logic [c_w-1:0]    r_y;
    logic [c_w-1:0]    r_res;
    logic [c_w-1:0]    r_d;
    logic [c_iw-1:0]   r_idx;
    logic              r_b;
    logic              r_bout;

    logic              w_accept;
    logic              w_last;
    logic [c_iw+1:0]   w_base;
    logic [3:0]        w_xn;
    logic [3:0]        w_yn;
    logic [3:0]        w_g;
    logic [3:0]        w_p;
    logic [4:0]        w_b;
    logic [3:0]        w_dn;
    logic [c_w-1:0]    w_res_full;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_idx == c_last);
    assign w_base   = {r_idx, 2'b00};
    assign w_xn     = r_x[w_base +: 4];
    assign w_yn     = r_y[w_base +: 4];

    // Borrow-lookahead slice: every internal borrow is a flat function of b0.
    assign w_g  = ~w_xn & w_yn;
    assign w_p  = ~(w_xn ^ w_yn);
    assign w_b[0] = r_b;
    assign w_b[1] = w_g[0] | (w_p[0] & r_b);
    assign w_b[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_b);
    assign w_b[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_b);
    assign w_b[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_b);
    assign w_dn = w_xn ^ w_yn ^ w_b[3:0];

    always_comb begin
        w_res_full = r_res;
        w_res_full[w_base +: 4] = w_dn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs D/Bout only move on the final nibble so they hold across IDLE and RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_res  <= '0;
            r_d    <= '0;
            r_idx  <= '0;
            r_b    <= 1'b0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_x   <= X;
            r_y   <= Y;
            r_b   <= Bin;
            r_idx <= '0;
            r_res <= '0;
        end else if (r_state == ST_RUN) begin
            r_res <= w_res_full;
            r_b   <= w_b[4];
            if (w_last) begin
                r_d    <= w_res_full;
                r_bout <= w_b[4];
            end else begin
                r_idx <= r_idx + c_iw'(1);
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign D    = r_d;
    assign Bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_lab3_serial_sub.sv
//==============================================================================
// Module  : tb_lab3_serial_sub
// Brief   : Directed bench for lab3_serial_sub with an expected-result queue.
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module tb_lab3_serial_sub;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic done_prev = 1'b0;

    logic [W:0] exp_q[$];
    int         acc_q[$];

    lab3_serial_sub #(.NIB(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .X     (X),
        .Y     (Y),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic b);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, b};
        return r;
    endfunction

    // Result checker: each done pops one expected result and checks latency.
    always @(negedge clk) begin
        if (rst_n) begin
            check("done_single_pulse", {31'd0, done_prev & done}, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", {31'd0, done}, 32'd0);
                end else begin
                    logic [W:0] e;
                    int a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("D", {16'd0, D}, {16'd0, e[W-1:0]});
                    check("Bout", {31'd0, Bout}, {31'd0, e[W]});
                    check("latency", cyc - a, NIB);
                end
            end
        end
        done_prev = done;
    end

    // Called #1 after a rising edge; the next edge accepts.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic b,
                            input bit expect_done);
        start = 1'b1;
        X = x;
        Y = y;
        Bin = b;
        if (expect_done) begin
            exp_q.push_back(model(x, y, b));
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_results();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        check("result_timeout", exp_q.size(), 0);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        X = '0;
        Y = '0;
        Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_D", {16'd0, D}, 32'd0);
        check("reset_Bout", {31'd0, Bout}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;

        // All-ones with borrow-in, busy window and done timing.
        start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        for (int i = 0; i < NIB; i++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("done_low_run", {31'd0, done}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("busy_after", {31'd0, busy}, 32'd0);
        check("done_high", {31'd0, done}, 32'd1);
        wait_results();

        start_op(16'h1000, 16'h0001, 1'b0, 1'b1);
        wait_results();
        start_op(16'h0000, 16'hFFFF, 1'b1, 1'b1);
        wait_results();
        start_op(16'h5555, 16'h5555, 1'b0, 1'b1);
        wait_results();
        start_op(16'hC00C, 16'h3003, 1'b1, 1'b1);
        wait_results();

        // Start during RUN is ignored; operand changes mid-run have no effect.
        start_op(16'h0001, 16'h000D, 1'b0, 1'b1);
        start = 1'b1;
        X = 16'hAAAA;
        Y = 16'h1234;
        Bin = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        X = 16'h7777;
        Y = 16'h0101;
        check("D_hold_in_run", {16'd0, D}, 32'h0000_9008);
        wait_results();

        // Back-to-back with start held high; second operands appear in DONE.
        start = 1'b1;
        X = 16'h0006;
        Y = 16'h0001;
        Bin = 1'b0;
        exp_q.push_back(model(16'h0006, 16'h0001, 1'b0));
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        repeat (NIB) @(posedge clk);
        #1;
        check("b2b_done", {31'd0, done}, 32'd1);
        X = 16'h000C;
        Y = 16'h0008;
        Bin = 1'b1;
        exp_q.push_back(model(16'h000C, 16'h0008, 1'b1));
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_results();

        // Leave Bout=1 in place, then abort an operation with async reset.
        start_op(16'h0000, 16'h0001, 1'b0, 1'b1);
        wait_results();
        start_op(16'h1234, 16'h0042, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_D", {16'd0, D}, 32'd0);
        check("async_rst_Bout", {31'd0, Bout}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_after_rst", {31'd0, busy}, 32'd0);
        start_op(16'h8000, 16'h0001, 1'b1, 1'b1);
        wait_results();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
